count_tracker: RTL and testbench

Receive-side companion to the 6-bit up/down counter: samples a free-running count value, locks onto its stepping direction, predicts each next value, and flags every deviation. Sits downstream of the counter, in the same clock domain, as a self-checking monitor for lab boards and regression benches. It reports lock status, the inferred direction, the number of wrap-arounds, and the number of sequence errors.

---
 rtl/count_tracker.sv | 207 ++++++++++++++++++++
 tb/tb_count_tracker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/count_tracker.sv
// -----------------------------------------------------------------------------
// count_tracker
// Receive-side monitor for a free-running up/down counter. It samples the
// observed count, locks onto the stepping direction, predicts every next
// value and flags each deviation. Wraps and errors are tallied in saturating
// counters.
//
// Parameters
//   WIDTH      : width of the observed count
//   MISS_LIMIT : consecutive mispredicted samples that drop lock (>= 1)
//   CNT_W      : width of the saturating wrap/error counters
//
// Ports
//   clock        : rising-edge clock
//   rst          : synchronous, active-high reset
//   sample_valid : sample is valid this cycle
//   sample       : observed count value
//   clear_cnt    : synchronous clear of wrap_count and err_count
//   locked       : tracker is in the LOCKED state
//   dir          : inferred direction, 0 = up (+1), 1 = down (-1)
//   wrap         : one-cycle pulse on a correctly predicted wrap-around
//   err          : one-cycle pulse on a mispredicted sample while locked
//   wrap_count   : saturating count of wraps
//   err_count    : saturating count of errors
// All outputs are registered; latency from a valid sample is one cycle.
// -----------------------------------------------------------------------------
module count_tracker #(
  parameter int WIDTH      = 6,
  parameter int MISS_LIMIT = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             dir,
  output logic             wrap,
  output logic             err,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int MISS_W = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);

  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_ZERO = '0;
  localparam logic [WIDTH-1:0]  VAL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  VAL_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  VAL_ONE   = WIDTH'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               locked_q, locked_d;
  logic               dir_q, dir_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]   exp_s;
  logic [WIDTH-1:0]   diff_s;
  logic [MISS_W-1:0]  miss_inc_s;
  logic               wrap_inc_s;
  logic               err_inc_s;

  // Saturating increment shared by both event counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // Prediction, step difference and next-state decode.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    miss_d     = miss_q;
    locked_d   = locked_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    wrap_inc_s = 1'b0;
    err_inc_s  = 1'b0;

    // All arithmetic wraps modulo 2^WIDTH by construction of the widths.
    exp_s      = dir_q ? (prev_q - VAL_ONE) : (prev_q + VAL_ONE);
    diff_s     = sample - prev_q;
    miss_inc_s = miss_q + MISS_ONE;

    if (sample_valid) begin
      case (state_q)
        ST_UNLOCKED: begin
          prev_d  = sample;
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          prev_d = sample;
          if (diff_s == VAL_ONE) begin
            dir_d    = 1'b0;
            miss_d   = MISS_ZERO;
            locked_d = 1'b1;
            state_d  = ST_LOCKED;
          end else if (diff_s == VAL_ONES) begin
            dir_d    = 1'b1;
            miss_d   = MISS_ZERO;
            locked_d = 1'b1;
            state_d  = ST_LOCKED;
          end else begin
            // Not a unit step: keep re-seeding silently.
            state_d = ST_ACQUIRE;
          end
        end
        ST_LOCKED: begin
          if (sample == exp_s) begin
            prev_d = sample;
            miss_d = MISS_ZERO;
            if ((!dir_q && (prev_q == VAL_ONES)) || (dir_q && (prev_q == VAL_ZERO))) begin
              wrap_d     = 1'b1;
              wrap_inc_s = 1'b1;
            end else begin
              wrap_d     = 1'b0;
            end
          end else begin
            err_d     = 1'b1;
            err_inc_s = 1'b1;
            if (miss_inc_s >= MISS_MAX) begin
              // Too many consecutive misses: reseed from the sample.
              prev_d   = sample;
              miss_d   = MISS_ZERO;
              locked_d = 1'b0;
              state_d  = ST_ACQUIRE;
            end else begin
              // Free-run the prediction so one glitch costs one error.
              prev_d = exp_s;
              miss_d = miss_inc_s;
            end
          end
        end
        default: begin
          state_d  = ST_UNLOCKED;
          locked_d = 1'b0;
          prev_d   = VAL_ZERO;
          miss_d   = MISS_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Clear wins over a coincident increment.
    if (clear_cnt) begin
      wrap_cnt_d = CNT_ZERO;
      err_cnt_d  = CNT_ZERO;
    end else begin
      wrap_cnt_d = wrap_inc_s ? sat_inc(wrap_cnt_q) : wrap_cnt_q;
      err_cnt_d  = err_inc_s  ? sat_inc(err_cnt_q)  : err_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= ST_UNLOCKED;
      prev_q     <= VAL_ZERO;
      miss_q     <= MISS_ZERO;
      locked_q   <= 1'b0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      wrap_cnt_q <= CNT_ZERO;
      err_cnt_q  <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign dir        = dir_q;
  assign wrap       = wrap_q;
  assign err        = err_q;
  assign wrap_count = wrap_cnt_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_count_tracker.sv
// -----------------------------------------------------------------------------
// tb_count_tracker
// Directed bench for count_tracker (WIDTH=6, MISS_LIMIT=2, CNT_W=2). Each step
// drives one cycle of stimulus and pushes the outputs expected after the next
// rising edge onto a queue; the entry is popped and compared once that edge
// has passed.
// -----------------------------------------------------------------------------
module tb_count_tracker;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [5:0] sample = 6'd0;
  logic       clear_cnt = 1'b0;
  logic       locked;
  logic       dir;
  logic       wrap;
  logic       err;
  logic [1:0] wrap_count;
  logic [1:0] err_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       locked;
    logic       dir;
    logic       wrap;
    logic       err;
    logic [1:0] wc;
    logic [1:0] ec;
  } exp_t;

  exp_t sb_q[$];

  count_tracker #(
    .WIDTH(6),
    .MISS_LIMIT(2),
    .CNT_W(2)
  ) dut (
    .clock(clock),
    .rst(rst),
    .sample_valid(sample_valid),
    .sample(sample),
    .clear_cnt(clear_cnt),
    .locked(locked),
    .dir(dir),
    .wrap(wrap),
    .err(err),
    .wrap_count(wrap_count),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic step(input logic v, input logic [5:0] s, input logic c, input logic r,
                      input logic el, input logic ed, input logic ew, input logic ee,
                      input logic [1:0] ewc, input logic [1:0] eec);
    exp_t e;
    rst          = r;
    sample_valid = v;
    sample       = s;
    clear_cnt    = c;
    e = '{locked: el, dir: ed, wrap: ew, err: ee, wc: ewc, ec: eec};
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    rst          = 1'b0;
    sample_valid = 1'b0;
    clear_cnt    = 1'b0;
    total++;
    assert (sb_q.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp("locked",     {7'd0, locked},     {7'd0, e.locked});
      cmp("dir",        {7'd0, dir},        {7'd0, e.dir});
      cmp("wrap",       {7'd0, wrap},       {7'd0, e.wrap});
      cmp("err",        {7'd0, err},        {7'd0, e.err});
      cmp("wrap_count", {6'd0, wrap_count}, {6'd0, e.wc});
      cmp("err_count",  {6'd0, err_count},  {6'd0, e.ec});
    end
  endtask

  // Reset cycle with a concurrent valid sample; everything must read zero.
  task automatic do_reset(input logic [5:0] s);
    step(1'b1, s, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Up lock: 5,6,7
    step(1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    // Invalid cycle with a wrong value changes nothing
    step(1'b0, 6'd33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Down wrap: 2,1,0,63,62
    do_reset(6'd9);
    step(1'b1, 6'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd63, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0);
    step(1'b1, 6'd62, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0);

    // Up wrap 63->0, then clear on an idle cycle
    do_reset(6'd0);
    step(1'b1, 6'd62, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
    step(1'b1, 6'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
    step(1'b0, 6'd1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Single glitch: lock at 10, then 11,40,13,14
    do_reset(6'd0);
    step(1'b1, 6'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1);
    step(1'b1, 6'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
    step(1'b1, 6'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);

    // Lock loss: lock at 20, then 50,51,52,53; then a downward step errs
    do_reset(6'd0);
    step(1'b1, 6'd19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1);
    step(1'b1, 6'd51, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2);
    step(1'b1, 6'd52, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
    step(1'b1, 6'd53, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
    step(1'b1, 6'd52, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3);
    step(1'b1, 6'd55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);

    // Saturation: lock at 31, five isolated glitches, err_count holds at 3
    do_reset(6'd0);
    step(1'b1, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1);
    step(1'b1, 6'd33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
    step(1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2);
    step(1'b1, 6'd35, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
    step(1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3);
    step(1'b1, 6'd37, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
    step(1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3);
    step(1'b1, 6'd39, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
    step(1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3);
    step(1'b1, 6'd41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
    // Clear coincident with an error: count zero, pulse still fires
    step(1'b1, 6'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    step(1'b1, 6'd43, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Reset mid-operation while locked with wrap_count=1, then relock
    do_reset(6'd0);
    step(1'b1, 6'd62, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
    do_reset(6'd1);
    step(1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step(1'b1, 6'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
